// File: rtl/aa_isa_pkg.sv
// AA instruction-set constants shared by the sequencer and datapath.
// Opcodes, field positions and sequencer state encoding.
package aa_isa_pkg;

    localparam logic [4:0] OP_MOVSGPR = 5'd0;
    localparam logic [4:0] OP_MOV     = 5'd1;
    localparam logic [4:0] OP_ADD     = 5'd2;
    localparam logic [4:0] OP_SUB     = 5'd3;
    localparam logic [4:0] OP_MUL     = 5'd4;
    localparam logic [4:0] OP_HALT    = 5'b11111;

    localparam int OPER_HI  = 31;
    localparam int OPER_LO  = 27;
    localparam int RDST_HI  = 26;
    localparam int RDST_LO  = 22;
    localparam int RSRC1_HI = 21;
    localparam int RSRC1_LO = 17;
    localparam int IMM_BIT  = 16;
    localparam int RSRC2_HI = 15;
    localparam int RSRC2_LO = 11;
    localparam int ISRC_HI  = 15;
    localparam int ISRC_LO  = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_ERR
    } seq_state_t;

    function automatic logic [4:0] oper_of(input logic [31:0] w);
        return w[OPER_HI:OPER_LO];
    endfunction

    function automatic logic [4:0] rdst_of(input logic [31:0] w);
        return w[RDST_HI:RDST_LO];
    endfunction

    function automatic logic [4:0] rsrc1_of(input logic [31:0] w);
        return w[RSRC1_HI:RSRC1_LO];
    endfunction

    function automatic logic imm_of(input logic [31:0] w);
        return w[IMM_BIT];
    endfunction

    function automatic logic [4:0] rsrc2_of(input logic [31:0] w);
        return w[RSRC2_HI:RSRC2_LO];
    endfunction

    function automatic logic [15:0] isrc_of(input logic [31:0] w);
        return w[ISRC_HI:ISRC_LO];
    endfunction

endpackage

// File: rtl/aa_seq_ctrl_if.sv
// Instruction-memory and datapath handshake bundle of the sequencer.
// master = sequencer side, slave = memory/datapath side.
interface aa_seq_ctrl_if #(
    parameter int PC_W = 8
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic [31:0]     ir;
    logic            dp_issue;
    logic            dp_done;
    logic            gpr_we;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output ir,
        output dp_issue,
        input  dp_done,
        output gpr_we
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  ir,
        input  dp_issue,
        output dp_done,
        input  gpr_we
    );
endinterface

// File: rtl/aa_decode.sv
// Opcode classifier for the AA ISA, shared with the datapath.
// Exactly one of the three outputs is high for any opcode.
module aa_decode
    import aa_isa_pkg::*;
(
    input  logic [4:0] oper,
    output logic       is_exec,
    output logic       is_halt,
    output logic       is_illegal
);

    // Opcodes 0..4 execute, 31 halts, everything else is illegal.
    always_comb begin
        is_exec    = (oper <= OP_MUL);
        is_halt    = (oper == OP_HALT);
        is_illegal = !is_exec && !is_halt;
    end

endmodule

// File: rtl/aa_seq_ctrl.sv
// AA instruction sequencer: fetch, decode, execute, writeback loop.
// Holds pc, ir and the retired-instruction counter.
module aa_seq_ctrl
    import aa_isa_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_pc,
    input  logic             halt_req,
    aa_seq_ctrl_if.master    bus,
    output logic [PC_W-1:0]  pc,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    seq_state_t state;
    seq_state_t nxt;
    logic [31:0] ir_q;
    logic        first_q;
    logic        is_exec;
    logic        is_halt;
    logic        is_illegal;
    logic        take_start;

    aa_decode u_dec (
        .oper       (oper_of(ir_q)),
        .is_exec    (is_exec),
        .is_halt    (is_halt),
        .is_illegal (is_illegal)
    );

    assign take_start    = start && (state == S_IDLE || state == S_ERR);
    assign bus.ir        = ir_q;
    assign bus.imem_addr = pc;

    // State register; first_q marks the issue cycle of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            first_q <= 1'b0;
        end else begin
            state   <= nxt;
            first_q <= (state == S_DECODE) && is_exec;
        end
    end

    // Next-state and Moore/Mealy outputs of the sequencer.
    always_comb begin
        nxt          = state;
        bus.imem_req = 1'b0;
        bus.dp_issue = 1'b0;
        bus.gpr_we   = 1'b0;
        done         = 1'b0;
        busy         = 1'b1;
        unique case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) nxt = S_FETCH;
            end
            S_FETCH: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) nxt = S_DECODE;
            end
            S_DECODE: begin
                unique case (1'b1)
                    is_exec: nxt = S_EXEC;
                    is_halt: begin
                        done = 1'b1;
                        nxt  = S_IDLE;
                    end
                    is_illegal: nxt = S_ERR;
                    default: nxt = S_ERR;
                endcase
            end
            S_EXEC: begin
                bus.dp_issue = first_q;
                if (bus.dp_done) nxt = S_WB;
            end
            S_WB: begin
                bus.gpr_we = 1'b1;
                if (halt_req) begin
                    done = 1'b1;
                    nxt  = S_IDLE;
                end else begin
                    nxt = S_FETCH;
                end
            end
            S_ERR: begin
                busy = 1'b0;
                if (start) nxt = S_FETCH;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Program counter: loaded on start, advanced (wrapping) in writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
        end else if (take_start) begin
            pc <= start_pc;
        end else if (state == S_WB) begin
            pc <= pc + 1'b1;
        end
    end

    // Instruction register only loads on an acknowledged fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_q <= '0;
        end else if (state == S_FETCH && bus.imem_ack) begin
            ir_q <= bus.imem_rdata;
        end
    end

    // Retired counter survives ERR and restarts; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired <= '0;
        end else if (state == S_WB) begin
            retired <= retired + 1'b1;
        end
    end

    // Sticky illegal flag: set entering ERR, cleared by a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (take_start) begin
            illegal <= 1'b0;
        end else if (state == S_DECODE && is_illegal) begin
            illegal <= 1'b1;
        end
    end

endmodule

// File: tb/tb_aa_seq_ctrl.sv
// Bench for aa_seq_ctrl: directed scenario table, hand sequences,
// and random programs checked against a per-instruction timing model.
module tb_aa_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  start_pc;
    logic        halt_req;
    logic [7:0]  pc;
    logic        busy;
    logic        done;
    logic        illegal;
    logic [15:0] retired;

    aa_seq_ctrl_if #(.PC_W(8)) bus ();

    aa_seq_ctrl #(.PC_W(8), .CNT_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .start_pc (start_pc),
        .halt_req (halt_req),
        .bus      (bus),
        .pc       (pc),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal),
        .retired  (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [256];
    int wait_tab [16];
    int lat_tab [16];
    int run_seq = 0;
    logic dp_auto = 1'b1;
    logic man_done = 1'b0;

    int seen = -1;
    int fn = 0;
    int inn = 0;
    int wc = 0;
    int lc = 1000;
    int cur_lat = 0;
    logic ack_r = 1'b0;
    logic [31:0] rdata_r = '0;
    logic auto_done = 1'b0;

    assign bus.imem_ack   = ack_r;
    assign bus.imem_rdata = rdata_r;
    assign bus.dp_done    = dp_auto ? auto_done : man_done;

    // Memory with per-fetch wait states and datapath with per-issue latency.
    always @(negedge clk) begin
        if (run_seq != seen) begin
            seen      <= run_seq;
            fn        <= 0;
            inn       <= 0;
            wc        <= 0;
            lc        <= 1000;
            ack_r     <= 1'b0;
            auto_done <= 1'b0;
        end else begin
            if (bus.imem_req) begin
                if (wc >= wait_tab[fn % 16]) begin
                    ack_r   <= 1'b1;
                    rdata_r <= mem[bus.imem_addr];
                    fn      <= fn + 1;
                end else begin
                    ack_r <= 1'b0;
                    wc    <= wc + 1;
                end
            end else begin
                ack_r <= 1'b0;
                wc    <= 0;
            end
            if (bus.dp_issue) begin
                lc        <= 0;
                cur_lat   <= lat_tab[inn % 16];
                inn       <= inn + 1;
                auto_done <= (lat_tab[inn % 16] == 0);
            end else begin
                if (lc < 1000) lc <= lc + 1;
                auto_done <= (lc < 1000) && (lc + 1 == cur_lat);
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    int obs_we [$];
    int obs_op [$];
    int obs_done [$];
    int obs_fa [$];
    int obs_iss;

    // Start a run at cycle 0 and record events until the sequencer idles.
    task automatic run(input logic [7:0] sp, input logic h);
        int cyc;
        logic prev_req;
        logic [7:0] prev_addr;
        obs_we.delete();
        obs_op.delete();
        obs_done.delete();
        obs_fa.delete();
        obs_iss = 0;
        prev_req = 1'b0;
        prev_addr = '0;
        run_seq++;
        start_pc = sp;
        halt_req = h;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 400) begin
            if (bus.gpr_we) begin
                obs_we.push_back(cyc);
                obs_op.push_back(int'(bus.ir[31:27]));
            end
            if (done) obs_done.push_back(cyc);
            if (bus.dp_issue) obs_iss++;
            if (bus.imem_req && !prev_req) obs_fa.push_back(int'(bus.imem_addr));
            if (bus.imem_req && prev_req)
                chk("addr_stable", int'(bus.imem_addr), int'(prev_addr));
            prev_req = bus.imem_req;
            prev_addr = bus.imem_addr;
            if (!busy) break;
            tick();
            cyc++;
        end
        chk("run_timeout", int'(cyc >= 400), 0);
    endtask

    int m_we [$];
    int m_done [$];
    int m_fa [$];
    int m_iss;
    int m_pc;
    int m_ret;
    int m_ill;

    // Instruction-level timing model: fetch w+1, decode 1, exec l+1, wb 1.
    task automatic model(input logic [7:0] sp, input logic h);
        int t;
        int k;
        int j;
        int d;
        int wb;
        int op;
        m_we.delete();
        m_done.delete();
        m_fa.delete();
        m_iss = 0;
        m_ill = 0;
        m_pc = int'(sp);
        t = 1;
        k = 0;
        j = 0;
        for (int n = 0; n < 64; n++) begin
            m_fa.push_back(m_pc);
            d = t + wait_tab[k % 16] + 1;
            k++;
            op = int'(mem[m_pc][31:27]);
            if (op == 31) begin
                m_done.push_back(d);
                break;
            end
            if (op > 4) begin
                m_ill = 1;
                break;
            end
            m_iss++;
            wb = d + 1 + lat_tab[j % 16] + 1;
            j++;
            m_we.push_back(wb);
            m_ret = (m_ret + 1) % 65536;
            m_pc = (m_pc + 1) % 256;
            if (h) begin
                m_done.push_back(wb);
                break;
            end
            t = wb + 1;
        end
    endtask

    typedef struct {
        logic [7:0]  sp;
        int          w;
        int          l;
        logic        h;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] w2;
        int          e_we;
        int          e_op;
        int          e_done;
        int          e_pc;
        int          e_ret;
        int          e_ill;
        int          e_nf;
        int          e_fa2;
        int          e_iss;
    } vec_t;

    localparam logic [31:0] W_ADD  = {5'd2, 5'd0, 5'd2, 1'b1, 16'd4};
    localparam logic [31:0] W_MUL  = {5'd4, 5'd3, 5'd1, 1'b0, 5'd2, 11'd0};
    localparam logic [31:0] W_MOV  = {5'd1, 5'd5, 5'd0, 1'b1, 16'h00ff};
    localparam logic [31:0] W_HALT = {5'd31, 27'd0};
    localparam logic [31:0] W_ILL  = {5'd7, 27'h5a5};

    vec_t tab [5];

    initial begin
        logic [7:0] a;
        int r;
        int n;
        logic [7:0] sp;
        logic h;
        int dact;

        tab[0] = '{8'd0,   0, 0, 1'b0, W_ADD, W_HALT, W_ADD,
                   4, 2, 6, 1, 1, 0, 2, 1, 1};
        tab[1] = '{8'd0,   2, 3, 1'b0, W_MUL, W_HALT, W_ADD,
                   9, 4, 13, 1, 1, 0, 2, 1, 1};
        tab[2] = '{8'd255, 0, 0, 1'b0, W_MOV, W_HALT, W_ADD,
                   4, 1, 6, 0, 1, 0, 2, 0, 1};
        tab[3] = '{8'd3,   0, 0, 1'b0, W_ILL, W_HALT, W_ADD,
                   -1, 0, -1, 3, 0, 1, 1, 0, 0};
        tab[4] = '{8'd0,   0, 0, 1'b1, W_ADD, W_ADD, W_ADD,
                   4, 2, 4, 1, 1, 0, 1, 0, 1};

        for (int i = 0; i < 256; i++) mem[i] = W_HALT;
        for (int i = 0; i < 16; i++) begin
            wait_tab[i] = 0;
            lat_tab[i] = 0;
        end
        rst_n = 1'b0;
        start = 1'b0;
        start_pc = '0;
        halt_req = 1'b0;
        #2;
        chk("rst_imem_req", int'(bus.imem_req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ir", int'(bus.ir), 0);
        chk("rst_pc", int'(pc), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_illegal", int'(illegal), 0);
        chk("rst_gpr_we", int'(bus.gpr_we), 0);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            do_reset();
            for (int e = 0; e < 16; e++) begin
                wait_tab[e] = tab[i].w;
                lat_tab[e] = tab[i].l;
            end
            a = tab[i].sp;
            mem[a] = tab[i].w0;
            a = a + 8'd1;
            mem[a] = tab[i].w1;
            a = a + 8'd1;
            mem[a] = tab[i].w2;
            run(tab[i].sp, tab[i].h);
            chk($sformatf("v%0d_we_count", i), obs_we.size(), tab[i].e_we < 0 ? 0 : 1);
            if (tab[i].e_we >= 0 && obs_we.size() > 0) begin
                chk($sformatf("v%0d_we_cycle", i), obs_we[0], tab[i].e_we);
                chk($sformatf("v%0d_we_op", i), obs_op[0], tab[i].e_op);
            end
            dact = obs_done.size() > 0 ? obs_done[0] : -1;
            chk($sformatf("v%0d_done_cycle", i), dact, tab[i].e_done);
            chk($sformatf("v%0d_fetches", i), obs_fa.size(), tab[i].e_nf);
            if (tab[i].e_nf >= 2 && obs_fa.size() >= 2)
                chk($sformatf("v%0d_fetch2_addr", i), obs_fa[1], tab[i].e_fa2);
            chk($sformatf("v%0d_pc", i), int'(pc), tab[i].e_pc);
            chk($sformatf("v%0d_retired", i), int'(retired), tab[i].e_ret);
            chk($sformatf("v%0d_illegal", i), int'(illegal), tab[i].e_ill);
            chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
            chk($sformatf("v%0d_issues", i), obs_iss, tab[i].e_iss);
        end

        // Restart out of ERR clears illegal and refetches start_pc.
        do_reset();
        mem[3] = W_ILL;
        run(8'd3, 1'b0);
        chk("err_illegal", int'(illegal), 1);
        chk("err_busy", int'(busy), 0);
        start_pc = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_illegal", int'(illegal), 0);
        chk("restart_req", int'(bus.imem_req), 1);
        chk("restart_addr", int'(bus.imem_addr), 3);
        for (int k = 0; k < 20 && busy; k++) tick();

        // Asynchronous reset in the middle of a MUL execute.
        do_reset();
        mem[0] = W_MUL;
        for (int e = 0; e < 16; e++) wait_tab[e] = 0;
        dp_auto = 1'b0;
        man_done = 1'b0;
        halt_req = 1'b0;
        start_pc = 8'd0;
        run_seq++;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 20 && !bus.dp_issue; k++) tick();
        chk("mid_issue_seen", int'(bus.dp_issue), 1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_req", int'(bus.imem_req), 0);
        chk("arst_issue", int'(bus.dp_issue), 0);
        chk("arst_ir", int'(bus.ir), 0);
        chk("arst_pc", int'(pc), 0);
        chk("arst_addr", int'(bus.imem_addr), 0);
        chk("arst_done", int'(done), 0);
        tick();
        rst_n = 1'b1;
        man_done = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_gpr_we", int'(bus.gpr_we), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        man_done = 1'b0;
        dp_auto = 1'b1;

        // Random programs against the timing model; state carries over.
        do_reset();
        m_ret = 0;
        for (int it = 0; it < 25; it++) begin
            for (int e = 0; e < 16; e++) begin
                wait_tab[e] = $urandom_range(0, 3);
                lat_tab[e] = $urandom_range(0, 3);
            end
            sp = 8'($urandom_range(0, 255));
            h = ($urandom_range(0, 3) == 0);
            n = $urandom_range(1, 5);
            a = sp;
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(0, 9);
                if (r < 8) r = $urandom_range(0, 4);
                else if (r == 8) r = 31;
                else r = $urandom_range(5, 30);
                mem[a] = {5'(r), 27'($urandom)};
                a = a + 8'd1;
            end
            mem[a] = {5'd31, 27'($urandom)};
            model(sp, h);
            run(sp, h);
            chk("rnd_we_count", obs_we.size(), m_we.size());
            for (int i = 0; i < obs_we.size() && i < m_we.size(); i++)
                chk("rnd_we_cycle", obs_we[i], m_we[i]);
            chk("rnd_done_count", obs_done.size(), m_done.size());
            if (obs_done.size() > 0 && m_done.size() > 0)
                chk("rnd_done_cycle", obs_done[0], m_done[0]);
            chk("rnd_fetch_count", obs_fa.size(), m_fa.size());
            for (int i = 0; i < obs_fa.size() && i < m_fa.size(); i++)
                chk("rnd_fetch_addr", obs_fa[i], m_fa[i]);
            chk("rnd_issues", obs_iss, m_iss);
            chk("rnd_pc", int'(pc), m_pc);
            chk("rnd_retired", int'(retired), m_ret);
            chk("rnd_illegal", int'(illegal), m_ill);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aa_seq_ctrl.md
# aa_seq_ctrl

Instruction sequencer for the AA register-transfer core. Fetches 32-bit instruction words from an external instruction memory, holds each in the instruction register that drives the AA datapath (ALU plus 32-entry GPR file), issues it, waits for completion and pulses the GPR write strobe. Sits between the instruction memory and the AA datapath and replaces the bench's direct `IR` pokes with a cycle-accurate fetch/decode/execute/writeback loop.

## Interface
- `PC_W`, 8: program-counter width in words.
- `CNT_W`, 16: retired-instruction counter width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: start pulse, sampled in IDLE or ERR.
- `start_pc` in PC_W: first fetch address, latched on `start`.
- `halt_req` in 1: stop request, sampled only in WB.
- `imem_req` out 1: fetch request, held high until acknowledged.
- `imem_addr` out PC_W: fetch address, equals `pc`.
- `imem_ack` in 1: fetch acknowledge, sampled at the clock edge while `imem_req` is high.
- `imem_rdata` in 32: instruction word, valid with `imem_ack`.
- `ir` out 32: instruction register driving the datapath.
- `dp_issue` out 1: one-cycle pulse, datapath starts executing `ir`.
- `dp_done` in 1: datapath result ready. Sampled in EXEC, including the issue cycle.
- `gpr_we` out 1: one-cycle write strobe for `ir[26:22]`.
- `pc` out PC_W: current instruction address.
- `busy` out 1: high in every state except IDLE and ERR.
- `done` out 1: one-cycle pulse on a HALT instruction or on `halt_req` exit.
- `illegal` out 1: sticky; set on entry to ERR.
- `retired` out CNT_W: count of instructions written back.

## Operation
- Fields: `oper_type` [31:27], `rdst` [26:22], `rsrc1` [21:17], `imm_mode` [16], `rsrc2` [15:11], `isrc` [15:0].
- Legal opcodes:
  - 0 MOVSGPR, 1 MOV, 2 ADD, 3 SUB, 4 MUL: execute.
  - 31 HALT: no execute, no write.
  - 5–30: illegal.
- States and transitions:
  - IDLE: on `start`, `pc` <= `start_pc`, clear `illegal`, go to FETCH.
  - FETCH: `imem_req`=1. On `imem_ack`, `ir` <= `imem_rdata`, go to DECODE.
  - DECODE: one cycle.
    - Legal execute opcode: go to EXEC.
    - HALT: pulse `done`, go to IDLE; `pc` is unchanged and points at the HALT word.
    - Illegal opcode: go to ERR.
  - EXEC: `dp_issue` is high in the first EXEC cycle only. Stay until `dp_done`=1, then go to WB.
  - WB: `gpr_we`=1; `pc` <= `pc`+1, wrapping modulo 2^PC_W; `retired` <= `retired`+1, wrapping.
    - If `halt_req`: pulse `done`, go to IDLE.
    - Otherwise go to FETCH.
  - ERR: `illegal`=1 and `busy`=0. Leave only on `start`, which behaves exactly as from IDLE. `retired` is kept.
- `start` outside IDLE/ERR is ignored. `halt_req` outside WB is ignored; it never aborts an outstanding fetch or execute.
- `ir` changes only on a FETCH acknowledge, so it is stable through DECODE, EXEC and WB.
- Reset values: all outputs 0, state IDLE, `ir`=0, `pc`=0, `retired`=0. An `rst_n` assertion at any point, mid-fetch or mid-execute, returns to IDLE immediately. No write strobe is emitted after reset.

## Timing
- With a zero-wait memory (`imem_ack` in the first FETCH cycle) and `dp_done` in the issue cycle, one instruction takes 4 cycles: FETCH, DECODE, EXEC, WB.
- Each memory wait cycle adds 1 cycle; each cycle of `dp_done` latency adds 1 cycle.
- `gpr_we` asserts exactly one cycle after the `dp_done` cycle.
- `start` to the first `imem_req`: 1 cycle.
- `imem_addr` is stable while `imem_req` is high.
- `done` and `gpr_we` coincide when `halt_req` is honoured in WB.

## Structure
- Package `aa_isa_pkg` holds:
  - opcode constants (`OP_MOVSGPR`…`OP_MUL`, `OP_HALT` = 5'b11111);
  - field bit positions;
  - the state enum (IDLE, FETCH, DECODE, EXEC, WB, ERR).
- Sub-module `aa_decode`: purely combinational. Maps `ir[31:27]` to `is_exec`, `is_halt`, `is_illegal`. The same decode is reused later by the datapath.
- The FSM, `pc`, `ir` and `retired` registers live in `aa_seq_ctrl`.

## Test plan
- Program {ADD imm `rsrc1`=2 `isrc`=4 `rdst`=0; HALT}, zero-wait memory, `dp_done` tied high, `start_pc`=0.
  - `gpr_we` in cycle 4 with `ir[31:27]`=2.
  - `done` in cycle 6.
  - Final `pc`=1, `retired`=1.
- Same program with 2 memory wait cycles and MUL taking 3 cycles.
  - `gpr_we` at cycle 9.
  - `dp_issue` is exactly one pulse.
  - `imem_addr` holds 0 during the waits.
- Opcode 7 at address 3.
  - ERR entered after DECODE; `illegal`=1, `busy`=0, no `gpr_we`.
  - A following `start` clears `illegal` and refetches from `start_pc`.
- `start_pc`=255 with PC_W=8, MOV then HALT.
  - The second fetch address is 0 (wrap).
  - `retired`=1.
- `halt_req` held high from cycle 1 over a 3-instruction program.
  - The first instruction completes (`gpr_we`=1); `done` coincides with it.
  - No second `imem_req`.
- `rst_n` low during EXEC of a MUL.
  - All outputs are 0 asynchronously; state IDLE.
  - `dp_done` arriving after reset produces no `gpr_we`.
